// File: rtl/multi_channel_clock_gate.sv
`default_nettype none
// ============================================================================
//  Module   : multi_channel_clock_gate
//  Brief    : NUM_CH independent glitch-free divided/gated clocks derived from
//             clk_in_i. Ratio changes and stops only take effect on period
//             boundaries. Per-channel sticky configuration error flags.
//             Optional macro CLKGATE_SYNC_EN: 2-flop synchronizers on
//             ch_en_i and err_clr_i (start/stop latency +2 edges).
//  Revision : 1.0 - initial release
// ============================================================================
module multi_channel_clock_gate #(
    parameter int NUM_CH  = 4,
    parameter int MAX_DIV = 8,
    parameter int RW      = $clog2(MAX_DIV + 1)
) (
    input  logic                 clk_in_i,
    input  logic                 rst_n_i,
    input  logic [NUM_CH-1:0]    ch_en_i,
    input  logic [NUM_CH*RW-1:0] ch_ratio_i,
    input  logic [NUM_CH-1:0]    err_clr_i,
    output logic [NUM_CH-1:0]    gated_clk_o,
    output logic [NUM_CH-1:0]    ch_pulse_o,
    output logic [NUM_CH-1:0]    ch_active_o,
    output logic [NUM_CH-1:0]    cfg_err_o
);

    localparam logic [RW-1:0] C_MAX_DIV = RW'(MAX_DIV);
    localparam logic [RW-1:0] C_ONE     = RW'(1);
    localparam logic [RW:0]   C_ONE_W   = (RW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    logic [NUM_CH-1:0] en_use;
    logic [NUM_CH-1:0] clr_use;

`ifdef CLKGATE_SYNC_EN
    logic [NUM_CH-1:0] en_s1_q, en_s2_q, clr_s1_q, clr_s2_q;

    // Two-flop synchronizers for asynchronous enable / clear sources
    always_ff @(posedge clk_in_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            en_s1_q  <= '0;
            en_s2_q  <= '0;
            clr_s1_q <= '0;
            clr_s2_q <= '0;
        end else begin
            en_s1_q  <= ch_en_i;
            en_s2_q  <= en_s1_q;
            clr_s1_q <= err_clr_i;
            clr_s2_q <= clr_s1_q;
        end
    end

    assign en_use  = en_s2_q;
    assign clr_use = clr_s2_q;
`else
    assign en_use  = ch_en_i;
    assign clr_use = err_clr_i;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t        state_q, state_d;
        logic [RW-1:0] cnt_q, cnt_d;
        logic [RW-1:0] ratio_q, ratio_d;
        logic          gclk_q, gclk_d;
        logic          pulse_q, pulse_d;
        logic          act_q, act_d;
        logic          err_q, err_d;
        logic [RW-1:0] r_in;
        logic [RW-1:0] cnt_inc;
        logic [RW:0]   half;
        logic          legal;
        logic          wrap;
        logic          err_set;

        assign r_in    = ch_ratio_i[i*RW +: RW];
        assign legal   = (r_in != '0) && (r_in <= C_MAX_DIV);
        assign wrap    = (cnt_q == (ratio_q - C_ONE));
        assign cnt_inc = cnt_q + C_ONE;
        // High phase length ceil(ratio/2); one extra bit avoids overflow at max ratio
        assign half    = ({1'b0, ratio_q} + C_ONE_W) >> 1;

        // Per-channel state, counter and registered outputs
        always_ff @(posedge clk_in_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                ratio_q <= '0;
                gclk_q  <= 1'b0;
                pulse_q <= 1'b0;
                act_q   <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                ratio_q <= ratio_d;
                gclk_q  <= gclk_d;
                pulse_q <= pulse_d;
                act_q   <= act_d;
                err_q   <= err_d;
            end
        end

        // Next-state: starts and stops only at period boundaries
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            ratio_d = ratio_q;
            gclk_d  = gclk_q;
            pulse_d = 1'b0;
            act_d   = act_q;
            err_set = 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_d  = '0;
                    gclk_d = 1'b0;
                    act_d  = 1'b0;
                    if (en_use[i]) begin
                        if (legal) begin
                            state_d = S_RUN;
                            ratio_d = r_in;
                            gclk_d  = 1'b1;
                            pulse_d = 1'b1;
                            act_d   = 1'b1;
                        end else begin
                            err_set = 1'b1;
                        end
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (wrap) begin
                        // Period boundary: re-latch ratio, decide continue/stop
                        cnt_d   = '0;
                        ratio_d = r_in;
                        if (en_use[i] && legal) begin
                            state_d = S_RUN;
                            gclk_d  = 1'b1;
                            pulse_d = 1'b1;
                            act_d   = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            gclk_d  = 1'b0;
                            act_d   = 1'b0;
                            err_set = en_use[i];
                        end
                    end else begin
                        cnt_d   = cnt_inc;
                        gclk_d  = ({1'b0, cnt_inc} < half);
                        act_d   = 1'b1;
                        state_d = en_use[i] ? S_RUN : S_DRAIN;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    gclk_d  = 1'b0;
                    act_d   = 1'b0;
                end
            endcase
            // Setting an error wins over a simultaneous clear
            err_d = err_set | (err_q & ~clr_use[i]);
        end

        assign gated_clk_o[i] = gclk_q;
        assign ch_pulse_o[i]  = pulse_q;
        assign ch_active_o[i] = act_q;
        assign cfg_err_o[i]   = err_q;
    end

endmodule
`default_nettype wire
